// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM controller arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic OWNER_A  = 1'b0;
    localparam logic OWNER_B  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_READY,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner select for the SRAM arbiter. A has priority; when
// SRAM_ARB_FAIRNESS_EN is defined, a streak counter forces a B grant after
// A_BURST_MAX consecutive A grants taken while B was waiting.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int unsigned A_BURST_MAX = 4
) (
`ifdef SRAM_ARB_FAIRNESS_EN
    input  logic clk,
    input  logic reset_n,
    input  logic eval_i,
`endif
    input  logic req_a_i,
    input  logic req_b_i,
    output logic pick_b_c
);

`ifdef SRAM_ARB_FAIRNESS_EN
    localparam int unsigned STREAK_W = $clog2(A_BURST_MAX + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                at_max_c;

    assign at_max_c = (streak_q == STREAK_W'(A_BURST_MAX));
    assign pick_b_c = req_b_i & (~req_a_i | at_max_c);

    // Streak update, only on IDLE evaluations; saturates at the limit.
    always_comb begin
        streak_d = streak_q;
        if (eval_i) begin
            if (!req_b_i || pick_b_c) begin
                streak_d = '0;
            end else if (req_a_i && !at_max_c) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    // Strict A priority.
    assign pick_b_c = req_b_i & ~req_a_i;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram_ctrl between the pixel writer (A) and SPI reader (B).
// Optional feature macro: SRAM_ARB_FAIRNESS_EN (bounded A streak while B waits).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned A_BURST_MAX    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              rw_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              done_a,
    input  logic              req_b,
    input  logic              rw_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              sram_start_n,
    output logic              sram_rw,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ready,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e          state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                start_n_q, start_n_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_a_q, done_a_d;
    logic                done_b_q, done_b_d;
    logic                grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                terr_q, terr_d;
    logic                pick_b_c;
    logic                tmo_hit_c;

    sram_arb_pick #(
        .A_BURST_MAX (A_BURST_MAX)
    ) u_pick (
`ifdef SRAM_ARB_FAIRNESS_EN
        .clk      (clk),
        .reset_n  (reset_n),
        .eval_i   (state_q == ST_IDLE),
`endif
        .req_a_i  (req_a),
        .req_b_i  (req_b),
        .pick_b_c (pick_b_c)
    );

    assign tmo_hit_c = (tmo_q >= TMO_W'(TIMEOUT_CYCLES));

    // Next state; outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        grant_d   = grant_q;
        terr_d    = terr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    grant_d = pick_b_c ? OWNER_B : OWNER_A;
                    rw_d    = pick_b_c ? rw_b    : rw_a;
                    addr_d  = pick_b_c ? addr_b  : addr_a;
                    wdata_d = pick_b_c ? wdata_b : wdata_a;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_hit_c) begin
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (!sram_ready) begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (sram_ready) begin
                    if (grant_q == OWNER_B && rw_q == RW_READ) begin
                        rdata_d = sram_rdata;
                    end
                    state_d = ST_DONE;
                end else if (tmo_hit_c) begin
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_n_d = (state_d != ST_ISSUE);
        busy_d    = (state_d != ST_IDLE);
        done_a_d  = (state_d == ST_DONE) && (grant_d == OWNER_A);
        done_b_d  = (state_d == ST_DONE) && (grant_d == OWNER_B);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            start_n_q <= 1'b1;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            start_n_q <= start_n_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
        end
    end

    assign sram_start_n = start_n_q;
    assign sram_rw      = rw_q;
    assign sram_addr    = addr_q;
    assign sram_wdata   = wdata_q;
    assign rdata_b      = rdata_q;
    assign done_a       = done_a_q;
    assign done_b       = done_b_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small reactive SRAM controller model.
module tb_sram_arbiter;

    localparam int unsigned AW   = 20;
    localparam int unsigned DW   = 16;
    localparam int unsigned TMO  = 64;
    localparam int unsigned BMAX = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_a = 1'b0, rw_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] wdata_a = '0;
    logic          done_a;
    logic          req_b = 1'b0, rw_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] wdata_b = '0;
    logic          done_b;
    logic [DW-1:0] rdata_b;
    logic          sram_start_n, sram_rw;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_ready = 1'b1;
    logic [DW-1:0] sram_rdata = '0;
    logic          grant, busy, timeout_err;

    int            n_chk = 0;
    int            n_bad = 0;

    logic          model_hang = 1'b0;
    logic [DW-1:0] model_data = '0;
    int            model_cnt  = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO), .A_BURST_MAX(BMAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .rw_a(rw_a), .addr_a(addr_a), .wdata_a(wdata_a), .done_a(done_a),
        .req_b(req_b), .rw_b(rw_b), .addr_b(addr_b), .wdata_b(wdata_b), .done_b(done_b),
        .rdata_b(rdata_b),
        .sram_start_n(sram_start_n), .sram_rw(sram_rw), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    // Controller model: ready low from cycle 2, high again in cycle 4 after start.
    always @(negedge clk) begin
        if (!model_hang) begin
            if (!sram_start_n) begin
                sram_ready = 1'b0;
                model_cnt  = 3;
            end else if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) begin
                    sram_ready = 1'b1;
                    sram_rdata = model_data;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction from an IDLE negedge (cycle 0); checks cycles 1..6.
    task automatic do_xact(input string tag, input logic is_b, input logic rw,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (is_b) begin
            req_b = 1'b1; rw_b = rw; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; rw_a = rw; addr_a = addr; wdata_a = wd;
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            chk({tag, ".start_n"}, 32'(sram_start_n), 32'(c != 1));
            chk({tag, ".done_a"},  32'(done_a),       32'(!is_b && c == 5));
            chk({tag, ".done_b"},  32'(done_b),       32'(is_b && c == 5));
            chk({tag, ".busy"},    32'(busy),         32'(c <= 5));
            if (c == 1) begin
                chk({tag, ".addr"},  32'(sram_addr), 32'(addr));
                chk({tag, ".rw"},    32'(sram_rw),   32'(rw));
                chk({tag, ".grant"}, 32'(grant),     32'(is_b));
                if (rw) chk({tag, ".wdata"}, 32'(sram_wdata), 32'(wd));
            end
            if (c == 5) begin
                if (is_b && !rw) chk({tag, ".rdata"}, 32'(rdata_b), 32'(model_data));
                if (is_b) req_b = 1'b0;
                else      req_a = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int last;
        int waited;
        logic exp_b;

        // Reset values.
        repeat (3) step();
        chk("rst.start_n", 32'(sram_start_n), 32'd1);
        chk("rst.busy",    32'(busy),         32'd0);
        chk("rst.grant",   32'(grant),        32'd0);
        chk("rst.terr",    32'(timeout_err),  32'd0);
        chk("rst.rdata_b", 32'(rdata_b),      32'd0);
        chk("rst.done",    32'({done_a, done_b}), 32'd0);
        reset_n = 1'b1;
        step();

        // A write alone.
        do_xact("a_wr", 1'b0, 1'b1, 20'h00123, 16'hBEEF);

        // B read at top address; data then held across an A read.
        model_data = 16'h5A5A;
        do_xact("b_rd", 1'b1, 1'b0, 20'hFFFFF, 16'h0000);
        step(); step();
        chk("b_rd.hold", 32'(rdata_b), 32'h5A5A);
        model_data = 16'h1234;
        do_xact("a_rd", 1'b0, 1'b0, 20'h00042, 16'h0000);
        chk("a_rd.b_untouched", 32'(rdata_b), 32'h5A5A);

        // Both requesting continuously for 20 transactions.
        req_a = 1'b1; rw_a = 1'b1; addr_a = 20'h00010; wdata_a = 16'h1111;
        req_b = 1'b1; rw_b = 1'b1; addr_b = 20'h00020; wdata_b = 16'h2222;
        cyc  = 0;
        last = 0;
        for (int t = 0; t < 20; t++) begin
            waited = 0;
            while (!(done_a || done_b) && waited < 40) begin
                step();
                cyc++;
                waited++;
            end
            chk("bb.wait_ok", 32'(waited < 40), 32'd1);
`ifdef SRAM_ARB_FAIRNESS_EN
            exp_b = ((t % 5) == 4);
`else
            exp_b = 1'b0;
`endif
            chk($sformatf("bb.done_b[%0d]", t), 32'(done_b), 32'(exp_b));
            chk($sformatf("bb.done_a[%0d]", t), 32'(done_a), 32'(!exp_b));
            chk($sformatf("bb.gap[%0d]", t), 32'(cyc - last), (t == 0) ? 32'd5 : 32'd6);
            last = cyc;
            if (t == 19) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            step();
            cyc++;
        end
        step(); step();
        chk("bb.idle", 32'(busy), 32'd0);

        // Timeout on a B read: controller never drops ready.
        model_hang = 1'b1;
        sram_rdata = 16'h7777;
        req_b = 1'b1; rw_b = 1'b0; addr_b = 20'h00005;
        waited = 0;
        while (!done_b && waited < 200) begin
            step();
            waited++;
        end
        chk("tmo.latency", 32'(waited), 32'(TMO + 3));
        chk("tmo.err",     32'(timeout_err), 32'd1);
        chk("tmo.rdata_b", 32'(rdata_b), 32'h5A5A);
        chk("tmo.done_a",  32'(done_a), 32'd0);
        req_b = 1'b0;
        step();
        model_hang = 1'b0;
        model_data = 16'h0000;
        do_xact("post_tmo", 1'b0, 1'b1, 20'h00777, 16'hCAFE);
        chk("post_tmo.sticky", 32'(timeout_err), 32'd1);

        // Reset in WAIT_READY.
        req_a = 1'b1; rw_a = 1'b1; addr_a = 20'h00ABC; wdata_a = 16'h0F0F;
        repeat (3) step();
        chk("mid.busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid.start_n", 32'(sram_start_n), 32'd1);
        chk("mid.busy",    32'(busy),         32'd0);
        chk("mid.terr",    32'(timeout_err),  32'd0);
        chk("mid.addr",    32'(sram_addr),    32'd0);
        chk("mid.wdata",   32'(sram_wdata),   32'd0);
        chk("mid.rw",      32'(sram_rw),      32'd0);
        chk("mid.rdata_b", 32'(rdata_b),      32'd0);
        chk("mid.grant",   32'(grant),        32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.no_done", 32'({done_a, done_b}), 32'd0);
        end
        reset_n = 1'b1;
        do_xact("post_rst", 1'b0, 1'b1, 20'h00ABC, 16'h0F0F);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and arbiter that shares the single SRAM controller between the pixel capture writer (port A) and the SPI frame reader (port B). It accepts level requests from both sides, selects one per transaction, issues a one-cycle start to `sram_ctrl`, tracks the controller's `ready` handshake to completion, and returns a done pulse (plus read data for B). It replaces the static `select` input of `single_mux`.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word address width.
- `DATA_W`, 16: SRAM data width.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting on `sram_ready` before a forced abort.
- `A_BURST_MAX`, 4: consecutive A grants allowed while B is pending (fairness build only).

Ports:
- `clk` in 1: system clock (`sys_clk`); only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_a` in 1: pixel writer request, level.
- `rw_a` in 1: 0 = read, 1 = write.
- `addr_a` in ADDR_W: address.
- `wdata_a` in DATA_W: write data.
- `done_a` out 1: single-cycle completion pulse.
- `req_b`, `rw_b`, `addr_b`, `wdata_b`, `done_b`: same as the A group, for the reader.
- `rdata_b` out DATA_W: read data, valid from the `done_b` cycle; held until the next B read completes.
- `sram_start_n` out 1: active-low start, one cycle per transaction.
- `sram_rw` out 1: registered copy of the granted `rw`.
- `sram_addr` out ADDR_W: registered granted address.
- `sram_wdata` out DATA_W: registered granted write data.
- `sram_ready` in 1: high when the controller is idle or its transaction is complete.
- `sram_rdata` in DATA_W: controller read data, valid when `sram_ready` rises.
- `grant` out 1: current owner, 0 = A, 1 = B.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky; set on timeout and cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE.
- **IDLE:** if either request is high, pick a winner, latch its rw/addr/wdata into the `sram_*` registers, set `grant`, and go to ISSUE. With no request, stay in IDLE.
- **Arbitration:**
  - Default: A wins when both requests are high (real-time pixel path).
  - Fairness build only: B wins when both are high and the streak counter equals `A_BURST_MAX`.
- **ISSUE:** `sram_start_n`=0 for exactly this cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** stay until `sram_ready`=0, then go to WAIT_READY.
- **WAIT_READY:** stay until `sram_ready`=1. On that edge, capture `sram_rdata` into `rdata_b` if `grant`=1 and `rw`=0, then go to DONE.
- **DONE:** pulse `done_a` or `done_b` per `grant`, then go to IDLE.
- **Timeout:**
  - A counter is cleared in ISSUE and increments in WAIT_BUSY and WAIT_READY.
  - When it reaches `TIMEOUT_CYCLES`: set `timeout_err`, go to DONE, and still pulse done. `rdata_b` is not updated.
- **Requester contract:**
  - Hold `req`, `rw`, `addr` and `wdata` stable until `done`.
  - Deassert `req` at the edge ending the done cycle, or keep it high to request back-to-back transactions.
  - A `req` drop before `done` is ignored; the transaction completes.
- **Reset (any time, including mid-transaction):** return to IDLE immediately. Reset values:
  - `sram_start_n`=1.
  - `sram_rw`, `sram_addr`, `sram_wdata`, `rdata_b`=0.
  - `done_a`, `done_b`, `grant`, `busy`, `timeout_err`=0.
  - Streak counter=0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request sampled in IDLE at cycle 0 gives:
  - `sram_start_n` low in cycle 1.
  - WAIT_BUSY from cycle 2.
  - `done` one cycle after the cycle in which `sram_ready` returns high.
- Minimum turnaround is 5 cycles, given a controller that drops `ready` in cycle 2 and raises it in cycle 4.
- Back-to-back: with a request held, the next ISSUE occurs 2 cycles after the previous DONE.
- Streak counter:
  - Increments on each A grant while `req_b`=1.
  - Clears on any B grant, or on any IDLE evaluation with `req_b`=0.
  - Saturates at `A_BURST_MAX`.

## Configuration
- `SRAM_ARB_FAIRNESS_EN` defined: the streak counter and B-override are compiled in, guaranteeing B a grant after at most `A_BURST_MAX` consecutive A grants.
- Undefined: strict A priority; no counter exists and `A_BURST_MAX` is unused.

## Structure
- Package `sram_arb_pkg` holds:
  - The state enum.
  - `RW_READ`=0 and `RW_WRITE`=1.
  - `OWNER_A`=0 and `OWNER_B`=1.
  - Default widths 20/16.
- One sub-module, `sram_arb_pick`, holds the winner-select and streak counter. It is instantiated once, and its counter is compiled out without the macro.

## Test plan
- **A write alone:** `req_a`=1, `rw_a`=1, `addr_a`=0x00123, `wdata_a`=0xBEEF; SRAM model lowers `ready` at cycle 2 and raises it at cycle 4.
  - Expect `sram_start_n`=0 only in cycle 1, with `sram_addr`=0x00123 and `sram_wdata`=0xBEEF.
  - Expect `done_a` in cycle 5.
- **B read:** `req_b`=1, `rw_b`=0, `addr_b`=0xFFFFF; model returns 0x5A5A.
  - Expect `done_b`=1 with `rdata_b`=0x5A5A, and `rdata_b` held afterwards.
- **Both requesting continuously, macro undefined:** all grants go to A; `done_b` never pulses over 20 transactions.
- **Both requesting continuously, macro defined, `A_BURST_MAX`=4:** grant sequence A,A,A,A,B,A,A,A,A,B.
- **Timeout:** model holds `ready`=1 forever after start.
  - Expect `timeout_err`=1 and `done` at `TIMEOUT_CYCLES`+3 after sampling.
  - Next transaction proceeds normally.
- **Reset mid-transaction:** assert `reset_n`=0 in WAIT_READY.
  - All outputs go to reset values asynchronously; no `done` pulse appears.
  - After release, a fresh A request completes in 5 cycles.
